// File: rtl/lfsr_decrypt_engine.sv
// lfsr_decrypt_engine
// Recovers plaintext from a 64-byte LFSR-encrypted message held in data
// memory. The known all-space preamble identifies the tap pattern and the
// seed. The recovered text is written back with its leading spaces removed
// and the tail padded with spaces. Every character is stored biased, as
// (char - 0x20).
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   init_n       asynchronous active-low reset
//   req          hold/idle while high; a high->low transition starts a run
//   ack          high while the finished result is presented (DONE)
//   mem_addr     read address (the memory returns data one cycle later)
//   mem_rd_data  read data
//   mem_wr_en    write strobe
//   mem_wr_addr  write address
//   mem_wr_data  write data (bit7 is always 0)
//   tap_idx      index 0..8 of the detected tap pattern; 4'hF if none
//   err          no tap pattern is consistent with the preamble
module lfsr_decrypt_engine #(
    parameter int IN_BASE  = 64,
    parameter int OUT_BASE = 0,
    parameter int MSG_LEN  = 64,
    parameter int PRE_MIN  = 10
) (
    input  logic       clk,
    input  logic       init_n,
    input  logic       req,
    output logic       ack,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rd_data,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_addr,
    output logic [7:0] mem_wr_data,
    output logic [3:0] tap_idx,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_MATCH, S_DECRYPT, S_PAD, S_DONE
    } state_t;

    function automatic logic [6:0] pattern(input logic [3:0] k);
        case (k)
            4'd0:    pattern = 7'h60;
            4'd1:    pattern = 7'h48;
            4'd2:    pattern = 7'h78;
            4'd3:    pattern = 7'h72;
            4'd4:    pattern = 7'h6A;
            4'd5:    pattern = 7'h69;
            4'd6:    pattern = 7'h5C;
            4'd7:    pattern = 7'h7E;
            4'd8:    pattern = 7'h7B;
            default: pattern = 7'h00;
        endcase
    endfunction

    function automatic logic [6:0] lfsr_next(input logic [6:0] s, input logic [6:0] p);
        lfsr_next = {s[5:0], ^(s & p)};
    endfunction

    state_t     state_q, state_d;
    logic       req_q, req_d;
    logic [6:0] cnt_q, cnt_d;
    logic [6:0] wp_q, wp_d;
    logic       seen_q, seen_d;
    logic [6:0] lfsr_q, lfsr_d;
    logic [6:0] pat_q, pat_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic       wr_en_q, wr_en_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic [3:0] tap_q, tap_d;
    logic       err_q, err_d;
    logic       ack_q, ack_d;
    logic [6:0] pre_q [PRE_MIN];
    logic [6:0] pre_d [PRE_MIN];

    logic [6:0]         cur_pat;
    logic [PRE_MIN-2:0] hit;
    logic [6:0]         plain;
    logic               unused_rd_msb;

    assign unused_rd_msb = mem_rd_data[7];
    assign cur_pat       = pattern(cnt_q[3:0]);
    assign plain         = mem_rd_data[6:0] ^ lfsr_q;

    // In LOAD, the byte requested on cycle n arrives on cycle n+1, so
    // preamble byte gi is captured when cnt_q == gi+1.
    // All preamble transitions are checked in parallel against the pattern
    // that is currently selected.
    generate
        for (genvar gi = 0; gi < PRE_MIN; gi++) begin : g_pre
            assign pre_d[gi] = (state_q == S_LOAD && cnt_q == 7'(gi + 1))
                               ? mem_rd_data[6:0] : pre_q[gi];
        end
        for (genvar gi = 0; gi < PRE_MIN - 1; gi++) begin : g_hit
            assign hit[gi] = (pre_q[gi+1] == lfsr_next(pre_q[gi], cur_pat));
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        req_d      = req;
        cnt_d      = cnt_q;
        wp_d       = wp_q;
        seen_d     = seen_q;
        lfsr_d     = lfsr_q;
        pat_d      = pat_q;
        mem_addr_d = mem_addr_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        tap_d      = tap_q;
        err_d      = err_q;
        ack_d      = ack_q;
        case (state_q)
            S_IDLE: begin
                if (req_q && !req) begin
                    state_d    = S_LOAD;
                    cnt_d      = 7'd0;
                    wp_d       = 7'd0;
                    seen_d     = 1'b0;
                    tap_d      = 4'hF;
                    err_d      = 1'b0;
                    mem_addr_d = 8'(IN_BASE);
                end
            end
            S_LOAD: begin
                if (cnt_q == 7'(PRE_MIN)) begin
                    state_d = S_MATCH;
                    cnt_d   = 7'd0;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                    if (cnt_q < 7'(PRE_MIN - 1))
                        mem_addr_d = 8'(IN_BASE) + {1'b0, cnt_q} + 8'd1;
                end
            end
            S_MATCH: begin
                if (&hit) begin
                    state_d    = S_DECRYPT;
                    tap_d      = cnt_q[3:0];
                    pat_d      = cur_pat;
                    // Byte 0 is the seed, so it also serves as the first LFSR state.
                    lfsr_d     = pre_q[0];
                    cnt_d      = 7'd0;
                    mem_addr_d = 8'(IN_BASE);
                end else if (cnt_q == 7'd8) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_DECRYPT: begin
                if (cnt_q < 7'(MSG_LEN - 1))
                    mem_addr_d = 8'(IN_BASE) + {1'b0, cnt_q} + 8'd1;
                // Cycle n consumes byte n-1. Output starts at the first
                // nonzero plaintext; every byte after that is kept.
                if (cnt_q != 7'd0) begin
                    lfsr_d = lfsr_next(lfsr_q, pat_q);
                    if (seen_q || plain != 7'd0) begin
                        seen_d    = 1'b1;
                        wr_en_d   = 1'b1;
                        wr_addr_d = 8'(OUT_BASE) + {1'b0, wp_q};
                        wr_data_d = {1'b0, plain};
                        wp_d      = wp_q + 7'd1;
                    end
                end
                if (cnt_q == 7'(MSG_LEN)) begin
                    if (wp_d == 7'(MSG_LEN)) begin
                        state_d = S_DONE;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = S_PAD;
                    end
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_PAD: begin
                wr_en_d   = 1'b1;
                wr_addr_d = 8'(OUT_BASE) + {1'b0, wp_q};
                wr_data_d = 8'h00;
                wp_d      = wp_q + 7'd1;
                if (wp_q == 7'(MSG_LEN - 1)) begin
                    state_d = S_DONE;
                    ack_d   = 1'b1;
                end
            end
            S_DONE: begin
                if (req) begin
                    state_d = S_IDLE;
                    ack_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            cnt_q      <= 7'd0;
            wp_q       <= 7'd0;
            seen_q     <= 1'b0;
            lfsr_q     <= 7'd0;
            pat_q      <= 7'd0;
            mem_addr_q <= 8'd0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 8'd0;
            wr_data_q  <= 8'd0;
            tap_q      <= 4'hF;
            err_q      <= 1'b0;
            ack_q      <= 1'b0;
            for (int i = 0; i < PRE_MIN; i++) pre_q[i] <= 7'd0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            cnt_q      <= cnt_d;
            wp_q       <= wp_d;
            seen_q     <= seen_d;
            lfsr_q     <= lfsr_d;
            pat_q      <= pat_d;
            mem_addr_q <= mem_addr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            tap_q      <= tap_d;
            err_q      <= err_d;
            ack_q      <= ack_d;
            for (int i = 0; i < PRE_MIN; i++) pre_q[i] <= pre_d[i];
        end
    end

    assign ack         = ack_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_wr_addr = wr_addr_q;
    assign mem_wr_data = wr_data_q;
    assign tap_idx     = tap_q;
    assign err         = err_q;

endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
// Self-checking bench for lfsr_decrypt_engine. A behavioural memory holds
// the ciphertext at 64..127 and receives the plaintext at 0..63. Each run
// pushes its expected write stream into a scoreboard queue, and a monitor
// pops that queue on every write strobe.
module tb_lfsr_decrypt_engine;

    logic       clk = 1'b0;
    logic       init_n;
    logic       req;
    logic       ack;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_addr;
    logic [7:0] mem_wr_data;
    logic [3:0] tap_idx;
    logic       err;

    lfsr_decrypt_engine dut (
        .clk(clk), .init_n(init_n), .req(req), .ack(ack),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .tap_idx(tap_idx), .err(err)
    );

    always #5 clk = ~clk;

    logic [7:0]  enc_mem [64];
    logic [7:0]  out_mem [64];
    logic [7:0]  exp_out [64];
    logic [15:0] exp_q [$];
    logic [3:0]  exp_tap;
    logic        exp_err;
    int cmp_cnt  = 0;
    int fail_cnt = 0;
    int wr_total = 0;

    always @(posedge clk) begin
        if (mem_wr_en) out_mem[mem_wr_addr[5:0]] <= mem_wr_data;
        mem_rd_data <= mem_addr[6] ? enc_mem[mem_addr[5:0]] : out_mem[mem_addr[5:0]];
    end

    always @(negedge clk) begin
        if (mem_wr_en) begin
            logic [15:0] got, want;
            wr_total++;
            cmp_cnt++;
            assert (exp_q.size() > 0) else begin
                fail_cnt++;
                $error("FAIL unexpected_write: observed addr %h data %h, required no write",
                       mem_wr_addr, mem_wr_data);
            end
            if (exp_q.size() > 0) begin
                got  = {mem_wr_addr, mem_wr_data};
                want = exp_q.pop_front();
                cmp_cnt++;
                assert (got === want) else begin
                    fail_cnt++;
                    $error("FAIL write: observed addr/data %h, required %h", got, want);
                end
            end
        end
    end

    function automatic logic [6:0] lfsr_next(input logic [6:0] s, input logic [6:0] p);
        return {s[5:0], ^(s & p)};
    endfunction

    function automatic logic [6:0] pat_of(input int k);
        logic [6:0] t [9];
        t = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
        return t[k];
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        cmp_cnt++;
        assert (obs === expv) else begin
            fail_cnt++;
            $error("FAIL %s: observed %h, required %h", tag, obs, expv);
        end
    endtask

    // Encrypts the preamble and the message. The model then searches the
    // taps, decrypts, strips and pads, and queues the expected writes.
    task automatic build(input logic [6:0] pat, input logic [6:0] seed, input int pre,
                         input string msg, input bit corrupt, input bit queue_writes);
        logic [6:0] s, ch, l, p;
        bit ok, seen;
        int wp;
        s = seed;
        for (int i = 0; i < 64; i++) begin
            ch = 7'd0;
            if (i >= pre && (i - pre) < msg.len()) ch = 7'(msg[i-pre] - 8'h20);
            enc_mem[i] = {1'($urandom_range(0, 1)), ch ^ s};
            s = lfsr_next(s, pat);
        end
        if (corrupt) enc_mem[5] = enc_mem[5] ^ 8'h01;
        exp_tap = 4'hF;
        for (int k = 0; k < 9; k++) begin
            ok = 1'b1;
            for (int i = 0; i < 9; i++)
                if (enc_mem[i+1][6:0] != lfsr_next(enc_mem[i][6:0], pat_of(k))) ok = 1'b0;
            if (ok && exp_tap == 4'hF) exp_tap = 4'(k);
        end
        exp_err = (exp_tap == 4'hF);
        if (!exp_err) begin
            l = enc_mem[0][6:0];
            seen = 1'b0;
            wp = 0;
            for (int i = 0; i < 64; i++) begin
                p = enc_mem[i][6:0] ^ l;
                l = lfsr_next(l, pat_of(int'(exp_tap)));
                if (seen || p != 7'd0) begin
                    seen = 1'b1;
                    if (queue_writes) exp_q.push_back({8'(wp), 1'b0, p});
                    exp_out[wp] = {1'b0, p};
                    wp++;
                end
            end
            for (int i = wp; i < 64; i++) begin
                if (queue_writes) exp_q.push_back({8'(i), 8'h00});
                exp_out[i] = 8'h00;
            end
        end
    endtask

    task automatic launch();
        req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ack_clear_on_req", {15'd0, ack}, 16'd0);
        req = 1'b0;
    endtask

    task automatic run_and_check(input string name);
        int lat;
        int wr_before;
        wr_before = wr_total;
        launch();
        lat = 0;
        while (!ack && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_ack"}, {15'd0, ack}, 16'd1);
        check({name, "_latency_le_160"}, {15'd0, (lat <= 160)}, 16'd1);
        @(negedge clk);
        @(negedge clk);
        check({name, "_tap_idx"}, {12'd0, tap_idx}, {12'd0, exp_tap});
        check({name, "_err"}, {15'd0, err}, {15'd0, exp_err});
        check({name, "_queue_empty"}, 16'(exp_q.size()), 16'd0);
        check({name, "_write_count"}, 16'(wr_total - wr_before), exp_err ? 16'd0 : 16'd64);
        for (int i = 0; i < 64; i++) check({name, "_mem"}, {8'd0, out_mem[i]}, {8'd0, exp_out[i]});
        $display("run %s: tap_idx=%0d err=%0b latency=%0d", name, tap_idx, err, lat);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ack"}, {15'd0, ack}, 16'd0);
        check({name, "_wr_en"}, {15'd0, mem_wr_en}, 16'd0);
        check({name, "_mem_addr"}, {8'd0, mem_addr}, 16'd0);
        check({name, "_wr_addr"}, {8'd0, mem_wr_addr}, 16'd0);
        check({name, "_wr_data"}, {8'd0, mem_wr_data}, 16'd0);
        check({name, "_tap_idx"}, {12'd0, tap_idx}, 16'h000F);
        check({name, "_err"}, {15'd0, err}, 16'd0);
    endtask

    initial begin
        int wr_mark;
        for (int i = 0; i < 64; i++) begin
            enc_mem[i] = 8'h00;
            exp_out[i] = 8'hA5;
        end
        init_n = 1'b0;
        req    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        init_n = 1'b1;

        // With req held low since reset, no run may start.
        repeat (30) @(negedge clk);
        check("no_launch_ack", {15'd0, ack}, 16'd0);
        check("no_launch_mem_addr", {8'd0, mem_addr}, 16'd0);
        check("no_launch_writes", 16'(wr_total), 16'd0);

        build(7'h60, 7'h01, 10, "Mr. Watson, come here. I want to see you.", 1'b0, 1'b1);
        run_and_check("watson");
        check("watson_mem0", {8'd0, out_mem[0]}, 16'h002D);

        // Holding req low after ack keeps ack high and does not start a second run.
        wr_mark = wr_total;
        repeat (200) @(negedge clk);
        check("hold_ack_high", {15'd0, ack}, 16'd1);
        check("hold_no_rerun", 16'(wr_total - wr_mark), 16'd0);

        build(7'h60, 7'h01, 10, "Mr. Watson, come here. I want to see you.", 1'b1, 1'b1);
        run_and_check("corrupt");

        build(7'h7B, 7'h5A, 15, " Knowledge comes, but wisdom lingers.    ", 1'b0, 1'b1);
        run_and_check("wisdom");
        check("wisdom_mem0", {8'd0, out_mem[0]}, 16'h002B);

        build(7'h5C, 7'h7F, 10, "", 1'b0, 1'b1);
        run_and_check("allspace");

        // Reset partway through DECRYPT aborts the run; nothing is written afterwards.
        build(7'h60, 7'h01, 10, "Mr. Watson, come here. I want to see you.", 1'b0, 1'b1);
        launch();
        repeat (50) @(negedge clk);
        init_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        wr_mark = wr_total;
        @(negedge clk);
        @(negedge clk);
        init_n = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_reset_no_writes", 16'(wr_total - wr_mark), 16'd0);
        check("mid_reset_ack", {15'd0, ack}, 16'd0);

        build(7'h60, 7'h01, 10, "Mr. Watson, come here. I want to see you.", 1'b0, 1'b1);
        run_and_check("watson_rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/lfsr_decrypt_engine.md
Name: lfsr_decrypt_engine

Overview:
- Hardware decryptor for messages produced by the program‑1 LFSR encryption scheme.
- Reads 64 encrypted bytes from data memory [64:127] and recovers the LFSR tap pattern and seed from the known all‑space preamble.
- Decrypts, strips leading spaces, and writes the biased plaintext (char − 0x20) to data memory [0:63], space‑padded at the tail.
- Attaches to the same data memory as the core, started and finished with the req/ack handshake used by top_level.

Parameters:
- IN_BASE, 64, data‑memory address of encrypted byte 0.
- OUT_BASE, 0, data‑memory address of plaintext byte 0.
- MSG_LEN, 64, number of encrypted/decrypted bytes.
- PRE_MIN, 10, guaranteed minimum preamble length; this many bytes are used for tap search.

Ports:
- clk  in  1  system clock, all state on rising edge.
- init_n  in  1  asynchronous active‑low reset.
- req  in  1  high = hold/idle; a high→low transition launches a run.
- ack  out  1  run complete; high in DONE.
- mem_addr  out  8  read address.
- mem_rd_data  in  8  read data, registered memory: valid one cycle after mem_addr.
- mem_wr_en  out  1  write strobe.
- mem_wr_addr  out  8  write address.
- mem_wr_data  out  8  write data; bit7 always 0.
- tap_idx  out  4  index 0..8 of the detected pattern (0x60,48,78,72,6A,69,5C,7E,7B); 4'hF if none.
- err  out  1  no pattern matched the preamble.

Behaviour:
- Reset (async, init_n=0): state IDLE; ack=0, mem_wr_en=0, mem_addr=0, mem_wr_addr=0, mem_wr_data=0, tap_idx=4'hF, err=0; buffers and counters cleared.
- Reset during any state aborts the run immediately. No write occurs after init_n falls.
- All LFSR arithmetic uses 7 bits; encrypted bit7 is ignored.
- Next LFSR state = {s[5:0], ^(s & P[6:0])}.
- Decrypt: p[i] = c[i][6:0] ^ lfsr[i]; lfsr[0] = c[0][6:0].
- States:
  - IDLE: waits for req sampled 1 then 0 on consecutive edges, then goes to LOAD. req low out of reset alone does not launch.
  - LOAD: issues reads IN_BASE..IN_BASE+PRE_MIN−1 back‑to‑back and captures c[0..9] into a 10×7 buffer. Takes PRE_MIN+1 cycles, then goes to MATCH.
  - MATCH: tests one pattern k per cycle, k=0..8. Pattern k matches if for all i in 0..8, c[i+1] == next(c[i], P_k). The first (lowest k) match sets tap_idx=k and goes to DECRYPT. No match after k=8 sets err=1, leaves tap_idx=4'hF, and goes to DONE with no writes.
  - DECRYPT: reads c[0..63] pipelined (one per cycle) and steps the LFSR once per consumed byte.
    - While no nonzero p has been seen, bytes are discarded (leading‑space strip). This covers preamble spaces and any leading spaces in the message itself.
    - From the first nonzero p onward, every byte (including zeros) is written to OUT_BASE+wp with bit7=0, and wp increments.
    - After byte 63, go to PAD.
  - PAD: writes 0x00 to OUT_BASE+wp .. OUT_BASE+63, one per cycle, then goes to DONE. If wp=64, PAD takes zero cycles.
  - DONE: ack=1, outputs held. When req goes high, clear ack and go to IDLE.
  - req changes outside IDLE/DONE are ignored.
- All‑space message: every p=0, so there are no DECRYPT writes and PAD writes 0x00 to all 64 locations.
- At most one write per cycle. Writes never target IN_BASE..IN_BASE+63.
- Latency from launch to ack ≤ 160 cycles (11 + 9 + 65 + 64 + margin).

Test Plan:
- Pattern 0x60, seed 0x01, pre_length 10, "Mr. Watson, come here. I want to see you.":
  - mem[0..40] = chars−0x20 (mem[0]=0x2D), mem[41..63]=0x00.
  - tap_idx=0, err=0, ack within 160 cycles of req fall.
- Pattern 0x7B, seed 0x5A, pre_length 15, " Knowledge comes, but wisdom lingers.    ":
  - mem[0]=0x2B ('K').
  - Message leading space and trailing spaces are stripped/padded to 0x00.
  - tap_idx=8.
- Preamble corrupted (c[5] ^= 0x01), otherwise as the first case:
  - err=1, tap_idx=4'hF.
  - No mem_wr_en pulse; mem[0..63] unchanged; ack=1.
- All‑space message, pattern 0x5C, seed 0x7F:
  - mem[0..63] all 0x00 (64 PAD writes), tap_idx=6.
- Assert init_n=0 for 2 cycles mid‑DECRYPT:
  - All outputs return to reset values; no further writes.
  - A subsequent req 1→0 completes the first case correctly.
- Handshake: hold req low from reset → no launch. Pulse req 1→0 → one run. After ack, hold req low → ack stays 1 and no second run.
